// File: rtl/cpu_bus_bridge_pkg.sv
// CPU bus bridge shared definitions.
// FSM encodings, write-buffer depth and buffer entry layout.
package cpu_bus_bridge_pkg;

   localparam int WBUF_DEPTH_C = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WR_BUSY = 2'd1;
   localparam logic [1:0] ST_RD_BUSY = 2'd2;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wbuf_entry_t;

endpackage

// File: rtl/cpu_bus_bridge_wbuf_fifo.sv
// Four-entry posted-write FIFO for the CPU bus bridge.
// Push and pop may occur together; pointers wrap modulo four.
module wbuf_fifo
   import cpu_bus_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic [23:0] din,
   output logic [23:0] dout,
   output logic [2:0]  count
);

   logic [23:0] mem [WBUF_DEPTH_C];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
         for (int i = 0; i < WBUF_DEPTH_C; i++)
            mem[i] <= 24'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/cpu_bus_bridge.sv
// CPU-to-memory bridge with posted writes and in-order stalled reads.
// Reads wait until every buffered write has retired.
module cpu_bus_bridge
   import cpu_bus_bridge_pkg::*;
#(
   parameter int WBUF_DEPTH = WBUF_DEPTH_C
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_address,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_data_o,
   output logic        cpu_ready,
   output logic [7:0]  cpu_data_i,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic [2:0]  wbuf_count,
   output logic        wbuf_overflow
);

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  last_rd;
   wbuf_entry_t head;
   logic        full;
   logic        push;
   logic        pop;
   logic        rd_ack;

   wbuf_fifo u_wbuf (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .din   ({cpu_address, cpu_data_o}),
      .dout  (head),
      .count (wbuf_count)
   );

   // Buffered writes take priority; a read only goes out on an empty buffer.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (reset) begin
         unique case (1'b1)
            state == ST_WR_BUSY: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
            end
            state == ST_RD_BUSY: mem_req = 1'b1;
            default: begin
               if (wbuf_count != 3'd0) begin
                  mem_req   = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = head.addr;
                  mem_wdata = head.data;
               end else if (!cpu_write) begin
                  mem_req  = 1'b1;
                  mem_addr = cpu_address;
               end
            end
         endcase
      end
   end

   assign pop    = mem_req && mem_we && mem_ack;
   assign rd_ack = mem_req && !mem_we && mem_ack;
   assign full   = wbuf_count == 3'(WBUF_DEPTH);
   assign push   = reset && cpu_write && (!full || pop);

   assign cpu_ready  = !reset || cpu_write || rd_ack;
   assign cpu_data_i = (rd_ack && !cpu_write) ? mem_rdata : last_rd;

   always_comb begin
      state_nx = state;
      if (state == ST_IDLE) begin
         if (mem_req && !mem_ack)
            state_nx = mem_we ? ST_WR_BUSY : ST_RD_BUSY;
      end else if (mem_ack) begin
         state_nx = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         addr_q        <= 16'h0000;
         wdata_q       <= 8'h00;
         last_rd       <= 8'h00;
         wbuf_overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
         end
         // A read finishing under a write cycle is discarded.
         if (rd_ack && !cpu_write)
            last_rd <= mem_rdata;
         if (cpu_write && full && !pop)
            wbuf_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench for cpu_bus_bridge.
// Transaction-level model plus directed scenarios with literal expectations.
module tb_cpu_bus_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] cpu_address;
   logic        cpu_write;
   logic [7:0]  cpu_data_o;
   logic        cpu_ready;
   logic [7:0]  cpu_data_i;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [2:0]  wbuf_count;
   logic        wbuf_overflow;

   int   checks = 0;
   int   failures = 0;
   bit   ack_en = 1'b0;
   bit   force_ack = 1'b0;
   int   ack_lat = 0;
   int   wc = 0;
   logic [7:0] rdata = 8'h00;

   always #5 clk = ~clk;

   cpu_bus_bridge #(.WBUF_DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_address   (cpu_address),
      .cpu_write     (cpu_write),
      .cpu_data_o    (cpu_data_o),
      .cpu_ready     (cpu_ready),
      .cpu_data_i    (cpu_data_i),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .wbuf_count    (wbuf_count),
      .wbuf_overflow (wbuf_overflow)
   );

   // Memory responder: ack after ack_lat waiting cycles of a request.
   assign mem_ack   = force_ack || (ack_en && mem_req && (wc >= ack_lat));
   assign mem_rdata = rdata;

   always @(posedge clk or negedge reset) begin
      if (!reset)
         wc <= 0;
      else if (mem_req && !mem_ack)
         wc <= wc + 1;
      else
         wc <= 0;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } ent_t;

   ent_t        mq[$];
   ent_t        wlog[$];
   int          okind = 0;
   logic [15:0] rd_a = 16'h0;
   logic [15:0] l_addr = 16'h0;
   logic [7:0]  l_wd = 8'h0;
   logic [7:0]  l_rd = 8'h0;
   bit          ovf_m = 1'b0;

   task automatic model_step();
      logic        e_req, e_we, e_rdy;
      logic [15:0] e_a;
      logic [7:0]  e_wd, e_di;
      bit          acked, rdk, pop, was_full;
      ent_t        ne;
      acked = 1'b0;
      rdk   = 1'b0;
      if (!reset) begin
         mq.delete();
         okind = 0; ovf_m = 1'b0;
         l_rd = 8'h0; l_addr = 16'h0; l_wd = 8'h0;
         e_req = 1'b0; e_we = 1'b0; e_a = 16'h0; e_wd = 8'h0;
         e_rdy = 1'b1; e_di = 8'h0;
      end else begin
         e_req = 1'b0; e_we = 1'b0; e_a = l_addr; e_wd = l_wd;
         if (okind == 2) begin
            e_req = 1'b1; e_a = rd_a;
         end else if (mq.size() > 0) begin
            e_req = 1'b1; e_we = 1'b1; e_a = mq[0].a; e_wd = mq[0].d;
         end else if (!cpu_write) begin
            e_req = 1'b1; e_a = cpu_address;
         end
         acked = e_req && mem_ack;
         rdk   = acked && !e_we;
         e_rdy = cpu_write || rdk;
         e_di  = (rdk && !cpu_write) ? mem_rdata : l_rd;
      end
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_a);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("cpu_ready", cpu_ready, e_rdy);
      chk("cpu_data_i", cpu_data_i, e_di);
      chk("wbuf_count", wbuf_count, mq.size());
      chk("wbuf_overflow", wbuf_overflow, ovf_m);
      if (reset) begin
         if (mem_req && mem_we && mem_ack)
            wlog.push_back('{mem_addr, mem_wdata});
         pop = acked && e_we;
         was_full = mq.size() >= 4;
         if (e_req) begin
            l_addr = e_a; l_wd = e_wd;
         end
         if (pop) void'(mq.pop_front());
         if (cpu_write) begin
            if (!was_full || pop) begin
               ne.a = cpu_address; ne.d = cpu_data_o;
               mq.push_back(ne);
            end else begin
               ovf_m = 1'b1;
            end
         end
         if (rdk && !cpu_write) l_rd = mem_rdata;
         okind = (e_req && !acked) ? (e_we ? 1 : 2) : 0;
         if (okind == 2) rd_a = e_a;
      end
   endtask

   initial begin : cmp
      forever begin
         @(negedge clk);
         #2;
         model_step();
      end
   end

   task automatic cyc(input bit w, input logic [15:0] a, input logic [7:0] dd);
      cpu_write = w; cpu_address = a; cpu_data_o = dd;
      #3;
      @(negedge clk);
   endtask

   task automatic cpu_read(input logic [15:0] a, output int n,
                           output logic [7:0] d);
      bit done;
      n = 0; d = 8'h0; done = 1'b0;
      cpu_write = 1'b0; cpu_address = a;
      while (!done && n < 60) begin
         #3;
         n++;
         if (cpu_ready) begin
            d = cpu_data_i;
            done = 1'b1;
         end
         @(negedge clk);
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL read_timeout: addr %h no cpu_ready after %0d cycles", a, n);
      end
   endtask

   initial begin : stim
      int          n;
      logic [7:0]  d;
      bit          tw [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [15:0] ta [5] = '{16'h1000, 16'h1000, 16'h2000, 16'h2001, 16'h3000};
      logic [7:0]  td [5] = '{8'hA1, 8'h00, 8'hB2, 8'hC3, 8'h00};

      cpu_write = 1'b0; cpu_address = 16'h0; cpu_data_o = 8'h0;
      @(negedge clk);
      #3;
      chk("rst_ready", cpu_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_count", wbuf_count, 0);
      @(negedge clk);

      // zero-wait read
      reset = 1'b1; ack_en = 1'b1; ack_lat = 0; rdata = 8'h34;
      cpu_read(16'hFFFC, n, d);
      chk("zw_cycles", n, 1);
      chk("zw_data", d, 8'h34);

      // three posted writes then an ordered read, latency 2
      ack_lat = 2; wlog.delete();
      cyc(1'b1, 16'h01FF, 8'h12);
      cyc(1'b1, 16'h01FE, 8'h34);
      cyc(1'b1, 16'h01FD, 8'h56);
      rdata = 8'h77;
      cpu_read(16'hFFFE, n, d);
      chk("ord_cycles", n, 10);
      chk("ord_data", d, 8'h77);
      chk("ord_nwr", wlog.size(), 3);
      if (wlog.size() == 3) begin
         chk("ord_wr0", {wlog[0].a, wlog[0].d}, 24'h01FF12);
         chk("ord_wr1", {wlog[1].a, wlog[1].d}, 24'h01FE34);
         chk("ord_wr2", {wlog[2].a, wlog[2].d}, 24'h01FD56);
      end

      // mixed traffic, latency 1
      ack_lat = 1; rdata = 8'h5C;
      for (int i = 0; i < 5; i++) begin
         if (tw[i]) cyc(1'b1, ta[i], td[i]);
         else begin
            cpu_read(ta[i], n, d);
            chk("mix_rdata", d, 8'h5C);
         end
      end

      // overflow: five writes with no acks
      reset = 1'b0;
      cyc(1'b1, 16'h0, 8'h0);
      reset = 1'b1; ack_en = 1'b0;
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 16'h0300 + 16'(i), 8'(i));
      chk("ovf_count", wbuf_count, 4);
      chk("ovf_flag", wbuf_overflow, 1);
      ack_en = 1'b1; ack_lat = 0; wlog.delete();
      cpu_read(16'h1234, n, d);
      chk("ovf_drain_cycles", n, 5);
      chk("ovf_sticky", wbuf_overflow, 1);
      chk("ovf_empty", wbuf_count, 0);
      chk("ovf_nwr", wlog.size(), 4);
      if (wlog.size() == 4)
         chk("ovf_last", {wlog[3].a, wlog[3].d}, 24'h030303);

      // full buffer, retire coincident with new write
      reset = 1'b0;
      cyc(1'b1, 16'h0, 8'h0);
      reset = 1'b1; ack_en = 1'b0;
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 16'h0400 + 16'(i), 8'h10 + 8'(i));
      chk("full_count", wbuf_count, 4);
      ack_en = 1'b1; ack_lat = 0; wlog.delete();
      cyc(1'b1, 16'h0200, 8'hAA);
      chk("full_keep", wbuf_count, 4);
      chk("full_noovf", wbuf_overflow, 0);
      cpu_read(16'h0000, n, d);
      chk("full_nwr", wlog.size(), 5);
      if (wlog.size() == 5) begin
         chk("full_first", {wlog[0].a, wlog[0].d}, 24'h040010);
         chk("full_last", {wlog[4].a, wlog[4].d}, 24'h0200AA);
      end

      // write cycle while a read is outstanding: read data discarded
      ack_en = 1'b0; rdata = 8'hEE;
      cyc(1'b0, 16'h4444, 8'h00);
      ack_en = 1'b1; ack_lat = 0;
      cpu_write = 1'b1; cpu_address = 16'h0500; cpu_data_o = 8'h05;
      #3;
      chk("rdx_ready", cpu_ready, 1);
      chk("rdx_data", cpu_data_i, 8'h5C);
      @(negedge clk);
      #3;
      chk("rdx_kept", cpu_data_i, 8'h5C);
      @(negedge clk);
      cpu_read(16'h0600, n, d);
      chk("rdx_next", d, 8'hEE);

      // reset during an outstanding read, then a stray ack
      ack_en = 1'b0;
      cyc(1'b0, 16'h7777, 8'h00);
      reset = 1'b0;
      #1;
      chk("rrst_req", mem_req, 0);
      chk("rrst_ready", cpu_ready, 1);
      chk("rrst_count", wbuf_count, 0);
      @(negedge clk);
      reset = 1'b1; force_ack = 1'b1;
      cpu_write = 1'b1; cpu_address = 16'h0800; cpu_data_o = 8'h08;
      #3;
      chk("rrst_lastrd", cpu_data_i, 8'h00);
      @(negedge clk);
      force_ack = 1'b0;
      chk("rrst_cnt1", wbuf_count, 1);
      #3;
      chk("rrst_issue", mem_addr, 16'h0800);
      @(negedge clk);
      ack_en = 1'b1;
      cpu_read(16'h0900, n, d);
      chk("rrst_drained", wbuf_count, 0);
      chk("rrst_noovf", wbuf_overflow, 0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
